// File: rtl/pll_mode_ctrl.sv
// PLL reset sequencing, lock qualification and runtime mode selection for the rPLL.
// Runs entirely on the 27 MHz reference clock; PLOCK is synchronised before use.
module pll_mode_ctrl #(
    parameter int unsigned MODE_W       = 2,
    parameter int unsigned NUM_MODES    = 3,
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              C27M,
    input  logic              RESET,
    input  logic              PLOCK,
    input  logic [MODE_W-1:0] MODE_REQ,
    input  logic              MODE_REQ_VALID,
    output logic              MODE_REQ_READY,
    output logic              PLL_RESET,
    output logic [MODE_W-1:0] PLL_SEL,
    output logic              VIDEO_RST,
    output logic              LOCKED,
    output logic              BAD_MODE,
    output logic              TIMEOUT_ERR,
    output logic [CNT_W-1:0]  LOCK_LOSS_CNT
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int unsigned MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(MAX_CNT + 1);

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    // WAIT_LOCK's first lock cycle already counts toward LOCK_STABLE.
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'((LOCK_STABLE >= 2) ? (LOCK_STABLE - 2) : 0);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX     = '1;

    localparam logic [1:0] ST_PLL_RST   = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [MODE_W-1:0] pll_sel_q, pll_sel_d;
    logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              bad_mode_q, bad_mode_d;
    logic              pll_reset_q, pll_reset_d;
    logic              video_rst_q, video_rst_d;
    logic              locked_q, locked_d;
    logic              lock_meta_q, lock_s_q;
    logic              req_bad_c;

    assign req_bad_c      = (32'(MODE_REQ) >= NUM_MODES);
    assign MODE_REQ_READY = (state_q == ST_RUN) && lock_s_q;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge C27M or posedge RESET) begin
        if (RESET) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= PLOCK;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge C27M or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_PLL_RST;
            tmr_q         <= '0;
            pll_sel_q     <= MODE_W'(DEFAULT_MODE);
            loss_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            bad_mode_q    <= 1'b0;
            pll_reset_q   <= 1'b1;
            video_rst_q   <= 1'b1;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            pll_sel_q     <= pll_sel_d;
            loss_cnt_q    <= loss_cnt_d;
            timeout_err_q <= timeout_err_d;
            bad_mode_q    <= bad_mode_d;
            pll_reset_q   <= pll_reset_d;
            video_rst_q   <= video_rst_d;
            locked_q      <= locked_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        pll_sel_d     = pll_sel_q;
        loss_cnt_d    = loss_cnt_q;
        timeout_err_d = timeout_err_q;
        bad_mode_d    = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    tmr_d = '0;
                    if (LOCK_STABLE < 2) state_d = ST_RUN;
                    else                 state_d = ST_STABLE;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_PLL_RST;
                    tmr_d         = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end else if (tmr_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss wins over a pending request; READY is already low.
                if (!lock_s_q) begin
                    if (loss_cnt_q != LOSS_MAX) loss_cnt_d = loss_cnt_q + CNT_W'(1);
                    state_d = ST_PLL_RST;
                    tmr_d   = '0;
                end else if (MODE_REQ_VALID) begin
                    if (req_bad_c) begin
                        bad_mode_d = 1'b1;
                    end else if (MODE_REQ != pll_sel_q) begin
                        pll_sel_d = MODE_REQ;
                        state_d   = ST_PLL_RST;
                        tmr_d     = '0;
                    end
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                tmr_d   = '0;
            end
        endcase

        pll_reset_d = (state_d == ST_PLL_RST);
        locked_d    = (state_d == ST_RUN);
        video_rst_d = !locked_d;
    end

    assign PLL_RESET     = pll_reset_q;
    assign PLL_SEL       = pll_sel_q;
    assign VIDEO_RST     = video_rst_q;
    assign LOCKED        = locked_q;
    assign BAD_MODE      = bad_mode_q;
    assign TIMEOUT_ERR   = timeout_err_q;
    assign LOCK_LOSS_CNT = loss_cnt_q;

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Directed bench for pll_mode_ctrl with short timing parameters.
module tb_pll_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       plock;
    logic [1:0] mode_req;
    logic       mode_req_valid;
    logic       mode_req_ready;
    logic       pll_reset;
    logic [1:0] pll_sel;
    logic       video_rst;
    logic       locked;
    logic       bad_mode;
    logic       timeout_err;
    logic [1:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    pll_mode_ctrl #(
        .MODE_W(2), .NUM_MODES(3), .DEFAULT_MODE(0),
        .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .CNT_W(2)
    ) dut (
        .C27M(clk), .RESET(rst), .PLOCK(plock),
        .MODE_REQ(mode_req), .MODE_REQ_VALID(mode_req_valid), .MODE_REQ_READY(mode_req_ready),
        .PLL_RESET(pll_reset), .PLL_SEL(pll_sel), .VIDEO_RST(video_rst), .LOCKED(locked),
        .BAD_MODE(bad_mode), .TIMEOUT_ERR(timeout_err), .LOCK_LOSS_CNT(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Waits for PLL_RESET to fall, raises PLOCK two cycles later, then expects
    // LOCKED/VIDEO_RST to release together 10 cycles after the raise
    // (2 synchroniser cycles + 8 stable cycles).
    task automatic relock(input string tag);
        int  n;
        logic prev_vr;
        plock = 1'b0;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL %s_pll_reset_width: got %0d expected 4", tag, n);
        end
        repeat (2) @(negedge clk);
        plock = 1'b1;
        n = 0;
        prev_vr = video_rst;
        while (locked !== 1'b1 && n < 60) begin
            prev_vr = video_rst;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL %s_lock_latency: got %0d expected 10", tag, n);
        end
        checks++;
        if (video_rst !== 1'b0 || prev_vr !== 1'b1) begin
            errors++;
            $display("FAIL %s_video_rst_edge: got now=%b before=%b expected now=0 before=1",
                     tag, video_rst, prev_vr);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        plock = 1'b0;
        mode_req = 2'd0;
        mode_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pll_reset, pll_sel, video_rst, locked, bad_mode, timeout_err, lock_loss_cnt, mode_req_ready}
            !== {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rst=%b sel=%0d vr=%b lk=%b bad=%b to=%b cnt=%0d rdy=%b expected 1 0 1 0 0 0 0 0",
                     pll_reset, pll_sel, video_rst, locked, bad_mode, timeout_err, lock_loss_cnt, mode_req_ready);
        end
    endtask

    task automatic test_power_up;
        rst = 1'b0;
        relock("power_up");
        checks++;
        if (pll_sel !== 2'd0 || mode_req_ready !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL power_up_state: got sel=%0d rdy=%b to=%b expected sel=0 rdy=1 to=0",
                     pll_sel, mode_req_ready, timeout_err);
        end
    endtask

    task automatic test_mode_change;
        mode_req = 2'd2;
        mode_req_valid = 1'b1;
        checks++;
        if (mode_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mode_change_ready: got %b expected 1", mode_req_ready);
        end
        @(negedge clk);
        mode_req_valid = 1'b0;
        checks++;
        if ({pll_sel, video_rst, locked, pll_reset} !== {2'd2, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mode_change_apply: got sel=%0d vr=%b lk=%b prst=%b expected 2 1 0 1",
                     pll_sel, video_rst, locked, pll_reset);
        end
        relock("mode_change");
        checks++;
        if (lock_loss_cnt !== 2'd0 || pll_sel !== 2'd2) begin
            errors++;
            $display("FAIL mode_change_after: got cnt=%0d sel=%0d expected cnt=0 sel=2",
                     lock_loss_cnt, pll_sel);
        end
    endtask

    task automatic test_bad_and_same_mode;
        mode_req = 2'd3;
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
        checks++;
        if (bad_mode !== 1'b1) begin
            errors++;
            $display("FAIL bad_mode_pulse: got %b expected 1", bad_mode);
        end
        @(negedge clk);
        checks++;
        if ({bad_mode, pll_sel, locked, pll_reset} !== {1'b0, 2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bad_mode_after: got bad=%b sel=%0d lk=%b prst=%b expected 0 2 1 0",
                     bad_mode, pll_sel, locked, pll_reset);
        end
        mode_req = 2'd2;
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({bad_mode, pll_sel, locked, pll_reset, video_rst} !== {1'b0, 2'd2, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL same_mode_noop[%0d]: got bad=%b sel=%0d lk=%b prst=%b vr=%b expected 0 2 1 0 0",
                         i, bad_mode, pll_sel, locked, pll_reset, video_rst);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock_loss_saturation;
        int exp_cnt [4] = '{1, 2, 3, 3};
        for (int i = 0; i < 4; i++) begin
            plock = 1'b0;
            repeat (2) @(negedge clk);
            // READY already low; a request arriving now must be ignored.
            mode_req = 2'd1;
            mode_req_valid = 1'b1;
            checks++;
            if (locked !== 1'b1 || mode_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL loss_sync_delay[%0d]: got lk=%b rdy=%b expected lk=1 rdy=0",
                         i, locked, mode_req_ready);
            end
            @(negedge clk);
            mode_req_valid = 1'b0;
            checks++;
            if ({locked, video_rst, pll_reset, pll_sel, lock_loss_cnt}
                !== {1'b0, 1'b1, 1'b1, 2'd2, 2'(exp_cnt[i])}) begin
                errors++;
                $display("FAIL loss_detect[%0d]: got lk=%b vr=%b prst=%b sel=%0d cnt=%0d expected 0 1 1 2 %0d",
                         i, locked, video_rst, pll_reset, pll_sel, lock_loss_cnt, exp_cnt[i]);
            end
            relock("loss_relock");
        end
    endtask

    task automatic test_reset_mid_stable;
        int n;
        plock = 1'b0;
        n = 0;
        while (pll_reset !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (pll_reset === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        plock = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (locked !== 1'b0 || lock_loss_cnt !== 2'd3) begin
            errors++;
            $display("FAIL mid_stable_pre: got lk=%b cnt=%0d expected lk=0 cnt=3", locked, lock_loss_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({pll_reset, pll_sel, video_rst, locked, bad_mode, timeout_err, lock_loss_cnt, mode_req_ready}
            !== {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_stable_reset: got rst=%b sel=%0d vr=%b lk=%b bad=%b to=%b cnt=%0d rdy=%b expected 1 0 1 0 0 0 0 0",
                     pll_reset, pll_sel, video_rst, locked, bad_mode, timeout_err, lock_loss_cnt, mode_req_ready);
        end
        plock = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_glitch;
        int n;
        rst = 1'b0;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        plock = 1'b1;
        repeat (4) @(negedge clk);
        plock = 1'b0;
        @(negedge clk);
        plock = 1'b1;
        // Stable count restarts: full 10-cycle latency measured from the re-raise.
        n = 0;
        while (locked !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL glitch_restart: got %0d expected 10", n);
        end
        checks++;
        if (lock_loss_cnt !== 2'd0 || video_rst !== 1'b0) begin
            errors++;
            $display("FAIL glitch_after: got cnt=%0d vr=%b expected cnt=0 vr=0", lock_loss_cnt, video_rst);
        end
    endtask

    task automatic test_timeout;
        int n;
        rst = 1'b1;
        plock = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected 32", n);
        end
        checks++;
        if (pll_reset !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_retry: got prst=%b lk=%b expected prst=1 lk=0", pll_reset, locked);
        end
        relock("timeout_retry");
        checks++;
        if (timeout_err !== 1'b1 || lock_loss_cnt !== 2'd0) begin
            errors++;
            $display("FAIL timeout_sticky: got to=%b cnt=%0d expected to=1 cnt=0", timeout_err, lock_loss_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_mode_change();
        test_bad_and_same_mode();
        test_lock_loss_saturation();
        test_reset_mid_stable();
        test_lock_glitch();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
